mux_sel_arbiter: RTL
====================

// Module: mux_sel_arbiter
// PURPOSE
//   Round-robin arbiter sharing one 2:1 select datapath (inputs a/b, select s, output y) between two requesters.
//   - Grants one channel at a time.
//   - Drives the datapath select so that s=0 routes a and s=1 routes b.
//   - Limits burst length so neither side starves.
//   - Sits directly in front of the select input of the shared datapath.
// PARAMETERS
//   MAX_BURST  8  max grant cycles before forced handover when the other side is waiting (2..2**CW)
//   CW         4  width of the burst counter
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-low (0 = in reset)
//   req_a      in   1   channel A requests the datapath; held high while it wants it
//   req_b      in   1   channel B requests the datapath
//   last_a     in   1   A's final beat this cycle; sampled only while gnt_a=1
//   last_b     in   1   B's final beat this cycle; sampled only while gnt_b=1
//   gnt_a      out  1   A owns the datapath this cycle
//   gnt_b      out  1   B owns the datapath this cycle
//   sel        out  1   datapath select: 0 = a, 1 = b
//   busy       out  1   gnt_a | gnt_b
//   burst_cnt  out  CW  cycles elapsed in the current grant (0 on the first granted cycle)
// BEHAVIOUR
//   - Reset values: gnt_a=0, gnt_b=0, sel=0, busy=0, burst_cnt=0, state=IDLE, last_owner=B.
//     With last_owner=B, A wins the first tie.
//   - All outputs are registered. Grant latency is 1 cycle: a request seen in cycle n gives a grant in cycle n+1.
//   - FSM states: IDLE, GNT_A, GNT_B. gnt_a=1 only in GNT_A; gnt_b=1 only in GNT_B.
//   - IDLE:
//     - req_a&req_b -> grant the channel != last_owner.
//     - req_a only -> GNT_A.
//     - req_b only -> GNT_B.
//     - neither -> stay in IDLE.
//   - GNT_X end condition: any one of
//     - req_x=0
//     - last_x=1
//     - timeout (see CONFIGURATION)
//   - On end: last_owner <= X. Next state:
//     - GNT_Y if req_y=1. Back-to-back handover, no idle cycle.
//     - else GNT_X (new burst) if req_x=1 and the end was by last_x or timeout.
//     - else IDLE.
//   - burst_cnt:
//     - 0 on entry to any GNT state, including a re-grant.
//     - +1 each cycle the grant holds.
//     - saturates at 2**CW-1.
//     - 0 in IDLE.
//   - sel: 0 in GNT_A, 1 in GNT_B. In IDLE it holds the last owner's value, so the datapath output does not glitch.
//   - Mutual exclusion: gnt_a & gnt_b is never 1, in any cycle.
//   - Simultaneous events:
//     - last_x together with a timeout counts as one end event.
//     - req_x=0 while gnt_x=1 ends the grant at the next edge, even if last_x was never seen.
//   - Reset asserted mid-grant: all outputs clear asynchronously. No burst state survives reset.
//   - Requests arriving during reset are ignored. They are evaluated from the first edge after release.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - A grant ends when burst_cnt == MAX_BURST-1 and the other req is high.
//     - Max wait for a requester is MAX_BURST+1 cycles.
//     - If the other req is low, the burst continues and burst_cnt saturates.
//   ARB_TIMEOUT_EN undefined:
//     - No preemption. A grant ends only on req_x=0 or last_x=1.
//     - burst_cnt is still reported.
// TESTING
//   1. Reset: reset=0 with req_a=req_b=1 -> all outputs 0.
//      Release reset -> cycle 1 gnt_a=1, sel=0, gnt_b=0.
//   2. Single requester: req_b=1 from IDLE, last_b=1 in the 3rd granted cycle ->
//      gnt_b=1 for 3 cycles, burst_cnt 0,1,2, sel=1, then IDLE with sel staying 1.
//   3. Round-robin tie: req_a=req_b=1 throughout, last_x pulsed on each 2nd granted cycle ->
//      grants alternate A,A,B,B,A,A with no idle gap.
//   4. Timeout (ARB_TIMEOUT_EN, MAX_BURST=8):
//      - A granted, req_b=1, last_a never pulsed -> gnt_a for exactly 8 cycles (burst_cnt 0..7), then gnt_b.
//      - Without the macro -> gnt_a held for 20+ cycles.
//   5. Drop mid-burst: gnt_a=1, req_a falls at burst_cnt=3, req_b=0 -> next cycle IDLE, busy=0, sel=0.
//   6. Async reset mid-grant: reset=0 at t=burst_cnt 2 + 0.2 cycle -> gnt_b/sel/busy/burst_cnt go to 0 before the next edge.
//   Every test: assert !(gnt_a & gnt_b) every cycle; assert sel matches the owner while busy.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a shared 2:1 datapath between requesters A and B.
// Optional burst timeout preemption is enabled by defining ARB_TIMEOUT_EN.
module mux_sel_arbiter #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          last_a,
    input  logic          last_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          sel,
    output logic          busy,
    output logic [CW-1:0] burst_cnt
);

`ifdef ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam logic [CW-1:0] BurstLast = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CntMax    = '1;

    typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

    state_e        state_q, state_d;
    logic          last_owner_q, last_owner_d;  // 0 = A, 1 = B
    logic [CW-1:0] cnt_d;
    logic          sel_d;
    logic          end_a, end_b, burst_end;

    always_comb begin
        end_a        = !req_a || last_a || (TimeoutEn && (burst_cnt == BurstLast) && req_b);
        end_b        = !req_b || last_b || (TimeoutEn && (burst_cnt == BurstLast) && req_a);
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_end    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_a && req_b) begin
                    state_d = last_owner_q ? StGntA : StGntB;
                end else if (req_a) begin
                    state_d = StGntA;
                end else if (req_b) begin
                    state_d = StGntB;
                end
            end
            StGntA: begin
                if (end_a) begin
                    burst_end    = 1'b1;
                    last_owner_d = 1'b0;
                    if (req_b)      state_d = StGntB;
                    else if (req_a) state_d = StGntA;
                    else            state_d = StIdle;
                end
            end
            StGntB: begin
                if (end_b) begin
                    burst_end    = 1'b1;
                    last_owner_d = 1'b1;
                    if (req_a)      state_d = StGntA;
                    else if (req_b) state_d = StGntB;
                    else            state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A re-grant after last/timeout starts a fresh burst, so the counter restarts too.
        if (state_d == StIdle || state_q == StIdle || burst_end) begin
            cnt_d = '0;
        end else if (burst_cnt != CntMax) begin
            cnt_d = burst_cnt + 1'b1;
        end else begin
            cnt_d = burst_cnt;
        end

        unique case (state_d)
            StGntA:  sel_d = 1'b0;
            StGntB:  sel_d = 1'b1;
            default: sel_d = sel;  // hold the last route so the datapath output stays stable
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt    <= '0;
            sel          <= 1'b0;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt    <= cnt_d;
            sel          <= sel_d;
            gnt_a        <= (state_d == StGntA);
            gnt_b        <= (state_d == StGntB);
            busy         <= (state_d != StIdle);
        end
    end

endmodule
